// File: rtl/ram_pkg.sv
// Shared definitions for the 1R1W byte-masked streaming RAM and its response queue.
package ram_pkg;

  // Number of entries in the read-response queue.
  localparam int RESP_DEPTH = 2;

  // Queue occupancy, 0..RESP_DEPTH.
  typedef logic [1:0] resp_cnt_t;

  // Occupancy at which the queue stops accepting new responses.
  localparam resp_cnt_t RESP_FULL_CNT = resp_cnt_t'(RESP_DEPTH);

  // Byte-mask width for a data word of the given width.
  function automatic int mask_width(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ram_resp_fifo.sv
// Two-entry in-order response queue for the streaming RAM read port.
//
// Handshake: the push side transfers when push_valid_i=1 and full_o=0; the
// pop side transfers when pop_valid_o=1 and pop_ready_i=1. full_o, pop_valid_o
// and pop_data_o depend on registered state only, so there is no combinational
// path from pop_ready_i or push_valid_i to any output. A push and a pop can
// happen on the same edge; order is preserved and the count is unchanged.
module ram_resp_fifo
  import ram_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               push_valid_i,
  input  logic [width_p-1:0] push_data_i,
  output logic               pop_valid_o,
  input  logic               pop_ready_i,
  output logic [width_p-1:0] pop_data_o,
  output logic               full_o
);

  logic [width_p-1:0] entries_q [RESP_DEPTH];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  resp_cnt_t          cnt_q, cnt_d;
  logic               push, pop;

  // Status flags come straight from the registered count.
  always_comb begin
    full_o      = (cnt_q == RESP_FULL_CNT);
    pop_valid_o = (cnt_q != 2'd0);
    pop_data_o  = '0;
    if (pop_valid_o) pop_data_o = entries_q[rd_ptr_q];
  end

  // Transfer qualification and next-state for pointers and count.
  always_comb begin
    push     = push_valid_i && !full_o;
    pop      = pop_valid_o && pop_ready_i;
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (!push && pop) cnt_d = cnt_q - 2'd1;
  end

  // Queue state; reset discards every held response.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < RESP_DEPTH; i++) entries_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push) entries_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_1r1w_be_stream.sv
// One-read/one-write synchronous RAM with per-byte write masks and a
// ready/valid read port backed by a two-entry response queue.
//
// Build option RAM_BYPASS_EN: when defined, a read accepted on the same edge
// as a write to the same in-range address returns the freshly written bytes
// (write-first). When undefined, it returns the old array contents
// (read-first). Writes behave identically in both builds.
//
// Read handshake: a request transfers when rd_valid_i=1 and rd_ready_o=1; a
// response transfers when rd_valid_o=1 and rd_ready_i=1. rd_ready_o is the
// queue's not-full flag and never depends combinationally on rd_ready_i.
module ram_1r1w_be_stream
  import ram_pkg::*;
#(
  parameter  int width_p       = 32,
  parameter  int depth_p       = 512,
  localparam int addr_width_lp = $clog2(depth_p),
  localparam int mask_width_lp = mask_width(width_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     wr_valid_i,
  input  logic [addr_width_lp-1:0] wr_addr_i,
  input  logic [width_p-1:0]       wr_data_i,
  input  logic [mask_width_lp-1:0] wr_mask_i,
  input  logic                     rd_valid_i,
  output logic                     rd_ready_o,
  input  logic [addr_width_lp-1:0] rd_addr_i,
  output logic                     rd_valid_o,
  output logic [width_p-1:0]       rd_data_o,
  input  logic                     rd_ready_i
);

  // One extra bit so depth_p itself is representable when depth_p is a power of two.
  localparam logic [addr_width_lp:0] depth_lp = (addr_width_lp + 1)'(depth_p);

  logic [width_p-1:0] mem_q [depth_p];

  logic               wr_in_range;
  logic               rd_in_range;
  logic               wr_en;
  logic               rd_accept;
  logic               fifo_full;
  logic [width_p-1:0] rd_word;
  logic [width_p-1:0] rd_push_data;

  // Address range checks and request qualification.
  always_comb begin
    wr_in_range = ({1'b0, wr_addr_i} < depth_lp);
    rd_in_range = ({1'b0, rd_addr_i} < depth_lp);
    wr_en       = wr_valid_i && wr_in_range && (wr_mask_i != '0);
    rd_ready_o  = !fifo_full;
    rd_accept   = rd_valid_i && rd_ready_o;
  end

  // Byte-masked array write; the array itself is never reset, and no write lands while reset is held.
  always_ff @(posedge clk_i) begin
    if (reset_ni && wr_en) begin
      for (int k = 0; k < mask_width_lp; k++) begin
        if (wr_mask_i[k]) mem_q[wr_addr_i][8*k +: 8] <= wr_data_i[8*k +: 8];
      end
    end
  end

  // Array read; out-of-range addresses return all zeros.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem_q[rd_addr_i];
  end

  // Same-edge read/write collision handling for the word pushed into the queue.
  always_comb begin
    rd_push_data = rd_word;
`ifdef RAM_BYPASS_EN
    if (wr_valid_i && wr_in_range && rd_in_range && (wr_addr_i == rd_addr_i)) begin
      for (int k = 0; k < mask_width_lp; k++) begin
        if (wr_mask_i[k]) rd_push_data[8*k +: 8] = wr_data_i[8*k +: 8];
      end
    end
`endif
  end

  ram_resp_fifo #(
    .width_p(width_p)
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .push_valid_i(rd_accept),
    .push_data_i (rd_push_data),
    .pop_valid_o (rd_valid_o),
    .pop_ready_i (rd_ready_i),
    .pop_data_o  (rd_data_o),
    .full_o      (fifo_full)
  );

endmodule

// File: tb/tb_ram_1r1w_be_stream.sv
// Bench for ram_1r1w_be_stream (depth 12, width 32) against a queue/array model.
module tb_ram_1r1w_be_stream;

  localparam int W     = 32;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int MW    = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          wr_valid_i = 1'b0;
  logic [AW-1:0] wr_addr_i  = '0;
  logic [W-1:0]  wr_data_i  = '0;
  logic [MW-1:0] wr_mask_i  = '0;
  logic          rd_valid_i = 1'b0;
  logic          rd_ready_o;
  logic [AW-1:0] rd_addr_i  = '0;
  logic          rd_valid_o;
  logic [W-1:0]  rd_data_o;
  logic          rd_ready_i = 1'b0;

  ram_1r1w_be_stream #(
    .width_p(W),
    .depth_p(DEPTH)
  ) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .wr_valid_i(wr_valid_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .wr_mask_i (wr_mask_i),
    .rd_valid_i(rd_valid_i),
    .rd_ready_o(rd_ready_o),
    .rd_addr_i (rd_addr_i),
    .rd_valid_o(rd_valid_o),
    .rd_data_o (rd_data_o),
    .rd_ready_i(rd_ready_i)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mem_m [DEPTH];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending responses plus the word array.
  always @(posedge clk_i) begin
    if (reset_ni) begin
      bit           acc, pop;
      logic [W-1:0] word;
      acc  = rd_valid_i && (exp_q.size() < 2);
      pop  = rd_ready_i && (exp_q.size() > 0);
      word = '0;
      if (acc && rd_addr_i < DEPTH) word = mem_m[rd_addr_i];
`ifdef RAM_BYPASS_EN
      if (acc && wr_valid_i && wr_addr_i < DEPTH && wr_addr_i == rd_addr_i)
        for (int k = 0; k < MW; k++)
          if (wr_mask_i[k]) word[8*k +: 8] = wr_data_i[8*k +: 8];
`endif
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(word);
      if (wr_valid_i && wr_addr_i < DEPTH)
        for (int k = 0; k < MW; k++)
          if (wr_mask_i[k]) mem_m[wr_addr_i][8*k +: 8] = wr_data_i[8*k +: 8];
    end
  end

  // Reset discards every pending response immediately.
  always @(negedge reset_ni) exp_q.delete();

  // Per-cycle compare of all read-port outputs against the model.
  always @(negedge clk_i) begin
    check("rd_valid_o", W'(rd_valid_o), W'(exp_q.size() != 0));
    check("rd_ready_o", W'(rd_ready_o), W'(exp_q.size() != 2));
    check("rd_data_o", rd_data_o, (exp_q.size() != 0) ? exp_q[0] : '0);
  end

  // ---------------- driver ----------------
  task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                      input logic [MW-1:0] wm, input logic rv, input logic [AW-1:0] ra,
                      input logic rr);
    wr_valid_i = wv; wr_addr_i = wa; wr_data_i = wd; wr_mask_i = wm;
    rd_valid_i = rv; rd_addr_i = ra; rd_ready_i = rr;
    @(negedge clk_i);
  endtask

  task automatic idle(input logic rr);
    step(1'b0, '0, '0, '0, 1'b0, '0, rr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk_i);
    // Reset held with a read request pending.
    step(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b1);
    check("reset_valid", W'(rd_valid_o), '0);
    check("reset_data", rd_data_o, '0);
    check("reset_ready", W'(rd_ready_o), W'(1));
    step(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b1);
    reset_ni = 1'b1;
    idle(1'b1);
    idle(1'b1);
    check("post_reset_no_resp", W'(rd_valid_o), '0);

    // Fill the array with a known pattern.
    for (int a = 0; a < DEPTH; a++) step(1'b1, AW'(a), 32'h1000_0000 + W'(a), 4'hF, 1'b0, '0, 1'b1);

    // Byte-masked overwrite.
    step(1'b1, 4'd5, 32'hDEAD_BEEF, 4'b1111, 1'b0, '0, 1'b1);
    step(1'b1, 4'd5, 32'h0000_0011, 4'b0001, 1'b0, '0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b1);
    check("masked_read", rd_data_o, 32'hDEAD_BE11);
    idle(1'b1);

    // Stall: only two requests accepted.
    step(1'b0, '0, '0, '0, 1'b1, 4'd1, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0);
    check("stall_ready_low", W'(rd_ready_o), '0);
    step(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
    check("stall_head1", rd_data_o, 32'h1000_0001);
    step(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b1);
    check("stall_head2", rd_data_o, 32'h1000_0002);
    check("stall_ready_back", W'(rd_ready_o), W'(1));
    step(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b1);
    check("stall_head3", rd_data_o, 32'h1000_0003);
    idle(1'b1);

    // Back-to-back streaming over 0..15.
    for (int a = 0; a < 16; a++) begin
      step(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b1);
      check("stream_ready", W'(rd_ready_o), W'(1));
      check("stream_valid", W'(rd_valid_o), W'(1));
    end
    idle(1'b1);
    check("stream_drained", W'(rd_valid_o), '0);

    // Same-edge read/write collision.
    step(1'b1, 4'd7, 32'h1122_3344, 4'hF, 1'b0, '0, 1'b1);
    step(1'b1, 4'd7, 32'hAABB_CCDD, 4'b0011, 1'b1, 4'd7, 1'b1);
`ifdef RAM_BYPASS_EN
    check("collision", rd_data_o, 32'h1122_CCDD);
`else
    check("collision", rd_data_o, 32'h1122_3344);
`endif
    step(1'b0, '0, '0, '0, 1'b1, 4'd7, 1'b1);
    check("after_collision", rd_data_o, 32'h1122_CCDD);
    idle(1'b1);

    // Out-of-range write and read.
    step(1'b1, 4'd13, 32'hFFFF_FFFF, 4'hF, 1'b0, '0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1, 4'd13, 1'b1);
    check("oor_read", rd_data_o, '0);
    step(1'b0, '0, '0, '0, 1'b1, 4'd11, 1'b1);
    check("addr11_intact", rd_data_o, 32'h1000_000B);
    idle(1'b1);

    // Asynchronous reset with a full queue; writes during reset are dropped.
    step(1'b0, '0, '0, '0, 1'b1, 4'd0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 4'd1, 1'b0);
    check("full_before_reset", W'(rd_ready_o), '0);
    #2 reset_ni = 1'b0;
    #1;
    check("async_valid", W'(rd_valid_o), '0);
    check("async_data", rd_data_o, '0);
    check("async_ready", W'(rd_ready_o), W'(1));
    @(negedge clk_i);
    step(1'b1, 4'd0, 32'hBAD0_BAD0, 4'hF, 1'b1, 4'd0, 1'b0);
    step(1'b1, 4'd0, 32'hBAD0_BAD0, 4'hF, 1'b1, 4'd0, 1'b0);
    reset_ni = 1'b1;
    idle(1'b1);
    step(1'b0, '0, '0, '0, 1'b1, 4'd0, 1'b1);
    check("no_write_in_reset", rd_data_o, 32'h1000_0000);
    idle(1'b1);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), W'($urandom),
           MW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    end
    idle(1'b1);
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
